i2c_bus_arbiter: RTL

Shares the single `i2c_controller` master between NUM_REQ on-board clients, such as the EEPROM reader and sensor pollers. Requesters are served round-robin, one byte transaction at a time. The block issues the one-cycle `enable` pulse to the controller and tracks its `ready` handshake. It enforces a post-transaction bus gap (EEPROM write-cycle time) and recovers the controller by reset on timeout.

---
 rtl/i2c_bus_arbiter_pkg.sv | 40 ++++
 rtl/i2c_bus_arbiter_if.sv | 45 ++++
 rtl/i2c_bus_arbiter_rr_picker.sv | 36 +++
 rtl/i2c_bus_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/i2c_bus_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// i2c_arb_pkg
//   Shared definitions for the I2C bus arbiter: FSM state type, the EEPROM
//   device base address and default timing constants. Also provides the
//   helper that sizes the arbiter's shared down-counter.
// ----------------------------------------------------------------------------
package i2c_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        GAP,
        RECOVER
    } arb_state_t;

    // 7-bit base address of the 24Cxx-style EEPROM on the board bus.
    localparam logic [6:0] EEPROM_BASE_ADDR = 7'b1010000;

    localparam int unsigned DEF_NUM_REQ       = 4;
    localparam int unsigned DEF_GAP_CYCLES    = 2000;
    localparam int unsigned DEF_START_TIMEOUT = 64;
    localparam int unsigned DEF_XFER_TIMEOUT  = 200000;
    localparam int unsigned DEF_RST_CYCLES    = 4;

    // One counter serves every timed phase, so it is sized for the largest.
    function automatic int unsigned cnt_width(input int unsigned gap_cycles,
                                              input int unsigned start_timeout,
                                              input int unsigned xfer_timeout,
                                              input int unsigned rst_cycles);
        int unsigned m;
        m = gap_cycles;
        if (start_timeout > m) m = start_timeout;
        if (xfer_timeout  > m) m = xfer_timeout;
        if (rst_cycles    > m) m = rst_cycles;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// i2c_bus_arbiter_if
//   Bundles the requester-side and controller-side signals of the arbiter.
//   master : the arbiter itself
//   slave  : the environment (client requesters plus the i2c_controller)
//
//   req/req_rw       per-client request and direction (0 write, 1 read)
//   req_addr         7 bits per client, client i at [7i+6:7i]
//   req_data         8 bits per client, write data / word address byte
//   gnt/done/err     per-client grant, completion and timeout pulses
//   rdata            last read byte
//   i2c_*            command / handshake to the shared controller
// ----------------------------------------------------------------------------
interface i2c_bus_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   req_rw;
    logic [7*NUM_REQ-1:0] req_addr;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   done;
    logic [NUM_REQ-1:0]   err;
    logic [7:0]           rdata;

    logic                 i2c_enable;
    logic                 i2c_rw;
    logic [6:0]           i2c_addr;
    logic [7:0]           i2c_data_in;
    logic [7:0]           i2c_data_out;
    logic                 i2c_ready;
    logic                 i2c_rst;

    modport master (
        input  req, req_rw, req_addr, req_data, i2c_data_out, i2c_ready,
        output gnt, done, err, rdata,
               i2c_enable, i2c_rw, i2c_addr, i2c_data_in, i2c_rst
    );

    modport slave (
        output req, req_rw, req_addr, req_data, i2c_data_out, i2c_ready,
        input  gnt, done, err, rdata,
               i2c_enable, i2c_rw, i2c_addr, i2c_data_in, i2c_rst
    );
endinterface

// File: rtl/i2c_bus_arbiter_rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin selector. The search starts at the client
//   after last_winner and wraps, so the most recent winner has the lowest
//   priority.
//   req          request vector
//   last_winner  index granted most recently
//   winner       index of the selected client (0 when none)
//   valid        at least one request is pending
// ----------------------------------------------------------------------------
module rr_picker #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_winner,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    always_comb begin
        int unsigned cand;
        winner = '0;
        valid  = 1'b0;
        cand   = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = 32'(last_winner) + off;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!valid && req[cand[IDX_W-1:0]]) begin
                valid  = 1'b1;
                winner = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// ----------------------------------------------------------------------------
// i2c_bus_arbiter
//   Shares one i2c_controller between NUM_REQ clients, one byte transaction
//   at a time, round-robin. Issues the one-cycle enable strobe, follows the
//   controller's ready handshake, enforces an idle gap after each transfer
//   and resets the controller when it stops responding.
//
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    i2c_bus_arbiter_if.master: requester and controller signals
//
//   Timeout behaviour: err is reported START_TIMEOUT+1 cycles after the
//   enable cycle if ready never falls, and XFER_TIMEOUT+1 cycles after the
//   first cycle ready is seen low if it never rises again. A ready edge
//   arriving on the last counted cycle still wins over the timeout.
//   GAP lasts GAP_CYCLES+1 cycles (one cycle when GAP_CYCLES is 0).
// ----------------------------------------------------------------------------
module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ       = DEF_NUM_REQ,
    parameter int unsigned GAP_CYCLES    = DEF_GAP_CYCLES,
    parameter int unsigned START_TIMEOUT = DEF_START_TIMEOUT,
    parameter int unsigned XFER_TIMEOUT  = DEF_XFER_TIMEOUT,
    parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES
) (
    input logic               clk,
    input logic               rst_n,
    i2c_bus_arbiter_if.master bus
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = cnt_width(GAP_CYCLES, START_TIMEOUT,
                                              XFER_TIMEOUT, RST_CYCLES);

    // Counter expires at 0, so a phase of N cycles loads N-1.
    localparam logic [CNT_W-1:0] START_LOAD =
        CNT_W'((START_TIMEOUT == 0) ? 0 : START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] XFER_LOAD =
        CNT_W'((XFER_TIMEOUT == 0) ? 0 : XFER_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RST_LOAD =
        CNT_W'((RST_CYCLES == 0) ? 0 : RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);

    arb_state_t         state;
    logic [IDX_W-1:0]   last_winner;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        return NUM_REQ'(1) << i;
    endfunction

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req         (bus.req),
        .last_winner (last_winner),
        .winner      (pick_idx),
        .valid       (pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            last_winner     <= IDX_W'(NUM_REQ - 1);
            idx             <= '0;
            cnt             <= '0;
            bus.gnt         <= '0;
            bus.done        <= '0;
            bus.err         <= '0;
            bus.rdata       <= '0;
            bus.i2c_enable  <= 1'b0;
            bus.i2c_rw      <= 1'b0;
            bus.i2c_addr    <= '0;
            bus.i2c_data_in <= '0;
            bus.i2c_rst     <= 1'b0;
        end else begin
            // Strobes default low; states below raise them for one cycle.
            bus.i2c_enable <= 1'b0;
            bus.done       <= '0;
            bus.err        <= '0;

            case (state)
                IDLE: begin
                    // A busy controller holds off the grant entirely.
                    if (pick_valid && bus.i2c_ready) begin
                        idx             <= pick_idx;
                        last_winner     <= pick_idx;
                        bus.i2c_rw      <= bus.req_rw[pick_idx];
                        bus.i2c_addr    <= bus.req_addr[7*pick_idx +: 7];
                        bus.i2c_data_in <= bus.req_data[8*pick_idx +: 8];
                        bus.gnt         <= onehot(pick_idx);
                        bus.i2c_enable  <= 1'b1;
                        state           <= ISSUE;
                    end
                end

                ISSUE: begin
                    cnt   <= START_LOAD;
                    state <= WAIT_BUSY;
                end

                WAIT_BUSY: begin
                    if (!bus.i2c_ready) begin
                        cnt   <= XFER_LOAD;
                        state <= WAIT_DONE;
                    end else if (cnt == '0) begin
                        bus.err     <= onehot(idx);
                        bus.gnt     <= '0;
                        bus.i2c_rst <= 1'b1;
                        cnt         <= RST_LOAD;
                        state       <= RECOVER;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                WAIT_DONE: begin
                    if (bus.i2c_ready) begin
                        // Captured for writes as well; clients ignore it then.
                        bus.rdata <= bus.i2c_data_out;
                        bus.done  <= onehot(idx);
                        bus.gnt   <= '0;
                        cnt       <= GAP_LOAD;
                        state     <= GAP;
                    end else if (cnt == '0) begin
                        bus.err     <= onehot(idx);
                        bus.gnt     <= '0;
                        bus.i2c_rst <= 1'b1;
                        cnt         <= RST_LOAD;
                        state       <= RECOVER;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                RECOVER: begin
                    if (cnt == '0) begin
                        bus.i2c_rst <= 1'b0;
                        cnt         <= GAP_LOAD;
                        state       <= GAP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                GAP: begin
                    // Requests are deliberately not looked at here.
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
